vend_change_dispenser: RTL and testbench
========================================

// Module: vend_change_dispenser
// PURPOSE
//  Pays out change/refund coins after a sale or cancel. Takes an amount, then drives the coin hopper one coin at a time.
//  Coin order is greedy 5/2/1, limited by the on-board inventory of each coin. It is the payout end of the vending coin path.
//  Sits between the vending controller (request side) and the hopper mechanism (coin_valid/coin_ack side).
// PARAMETERS
//  BAL_W        4   width of amounts (request, remaining, shortfall)
//  CNT_W        4   width of each per-denomination inventory counter
//  INIT_CNT     8   inventory loaded into every counter at reset
//  ACK_TIMEOUT  15  max cycles in EMIT without coin_ack before jam fault
// PORTS
//  clk           in   1      clock
//  reset         in   1      asynchronous, active-high reset
//  req_valid     in   1      payout request
//  req_amount    in   BAL_W  amount to pay out
//  req_ready     out  1      high when state==IDLE
//  coin_valid    out  1      coin presented to hopper
//  coin_value    out  3      3'd1 / 3'd2 / 3'd5, same encoding as coin acceptor input
//  coin_ack      in   1      hopper released the presented coin
//  refill_valid  in   1      inventory refill strobe
//  refill_denom  in   3      1/2/5; any other value: refill ignored
//  refill_count  in   CNT_W  coins added
//  done          out  1      1-cycle pulse, payout finished
//  shortfall     out  BAL_W  unpaid amount; valid with done, held until next accept
//  jam           out  1      hopper fault
//  jam_clear     in   1      operator clears fault
//  cnt_1/cnt_2/cnt_5 out CNT_W  current inventory
// BEHAVIOUR
//  Reset: state IDLE; coin_valid, done, jam, shortfall = 0; coin_value = 0; all counts = INIT_CNT.
//   Reset is asynchronous and aborts any payout: coin_valid drops immediately.
//  States: IDLE, SELECT, EMIT, DONE, FAULT.
//  IDLE: on req_valid & req_ready, latch rem = req_amount and go to SELECT.
//  SELECT (1 cycle): choose the first match, using registered counts:
//   rem>=5 & cnt_5>0 -> pick 5
//   rem>=2 & cnt_2>0 -> pick 2
//   rem>=1 & cnt_1>0 -> pick 1
//   On a pick: register coin_value, go to EMIT.
//   No pick: shortfall = rem (0 if rem==0), go to DONE.
//   Pure greedy is the decided algorithm. No backtracking: 6 with {5:1, 2:n, 1:0} pays 5 and reports shortfall 1.
//  EMIT: coin_valid=1, coin_value stable until acked.
//   On coin_ack: rem -= value, decrement that count, clear timer, go to SELECT.
//   Timer counts cycles in EMIT. If ACK_TIMEOUT is reached with no ack: go to FAULT, drop coin_valid, no decrement.
//  DONE: done=1 for one cycle, then IDLE.
//  FAULT: jam=1, req_ready=0, rem preserved.
//   On jam_clear: shortfall = rem, go to DONE, jam=0.
//  Latency:
//   First coin_valid rises 2 cycles after accept.
//   Minimum 1 cycle of coin_valid, then 1 SELECT cycle between coins.
//   req_amount=0: done 2 cycles after accept, no coin_valid.
//  coin_ack outside EMIT is ignored. jam_clear outside FAULT is ignored.
//  Refill: accepted in any state. Adds refill_count to the selected counter, saturating at 2^CNT_W-1.
//   Refill and ack decrement on the same denom in the same cycle: cnt + refill_count - 1, saturated; no update lost.
//   Decrement of a counter at 0 cannot happen, because SELECT requires count>0.
//  Width rules: rem never underflows, because a pick requires rem >= value. All arithmetic is unsigned.
// STRUCTURE
//  vend_pkg: coin_t enum (COIN_NONE=0, COIN_1=1, COIN_2=2, COIN_5=5) and chg_state_t.
//   The coin acceptor shares coin_t.
//  Sub-module vend_coin_store: three CNT_W counters with saturating refill + ack decrement, exposing cnt_1/2/5.
//  Top holds the FSM, rem register and timeout timer.
// TESTING
//  1. req 7, full inventory -> coins 5 then 2, done, shortfall 0; cnt_5=7, cnt_2=7, cnt_1=8.
//  2. req 4 with cnt_2 drained to 0 -> four 1-coins, shortfall 0, cnt_1=4.
//  3. req 6, cnt_5=1, cnt_2=8, cnt_1=0 -> one 5-coin, then done with shortfall 1.
//  4. hold coin_ack low 15 cycles on req 7 -> jam=1, coin_valid=0, req_ready=0;
//     jam_clear -> done, shortfall 7, counts unchanged.
//  5. cnt_2=14 (CNT_W=4), refill denom 2 count 3 in the same cycle as ack of a 2-coin -> cnt_2=15.
//  6. reset asserted mid-EMIT -> coin_valid=0 at once, counts=INIT_CNT;
//     req 0 afterwards -> done 2 cycles after accept, no coin.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module : vend_pkg
// Brief  : Shared coin encoding and change-dispenser state type.
// Rev    : 1.0  initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [2:0] {
    COIN_NONE = 3'd0,
    COIN_1    = 3'd1,
    COIN_2    = 3'd2,
    COIN_5    = 3'd5
  } coin_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_EMIT   = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } chg_state_t;

endpackage
`default_nettype wire

// File: rtl/vend_change_dispenser_if.sv
`default_nettype none
// ============================================================================
// Module : vend_change_dispenser_if
// Brief  : Request handshake (controller side) and coin handshake (hopper side).
// Rev    : 1.0  initial release
// ============================================================================
interface vend_change_dispenser_if #(
  parameter int BAL_W = 4
);
  import vend_pkg::*;

  logic             req_valid;
  logic [BAL_W-1:0] req_amount;
  logic             req_ready;
  logic             coin_valid;
  coin_t            coin_value;
  logic             coin_ack;
  logic             done;
  logic [BAL_W-1:0] shortfall;

  modport master (
    output req_valid, req_amount, coin_ack,
    input  req_ready, coin_valid, coin_value, done, shortfall
  );

  modport slave (
    input  req_valid, req_amount, coin_ack,
    output req_ready, coin_valid, coin_value, done, shortfall
  );
endinterface
`default_nettype wire

// File: rtl/vend_coin_store.sv
`default_nettype none
// ============================================================================
// Module : vend_coin_store
// Brief  : Per-denomination coin inventory with saturating refill and payout decrement.
// Rev    : 1.0  initial release
// ============================================================================
module vend_coin_store
  import vend_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             refill_valid,
  input  wire logic [2:0]       refill_denom,
  input  wire logic [CNT_W-1:0] refill_count,
  input  wire logic             dec_valid,
  input  wire coin_t            dec_coin,
  output logic      [CNT_W-1:0] cnt_1,
  output logic      [CNT_W-1:0] cnt_2,
  output logic      [CNT_W-1:0] cnt_5
);

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    localparam coin_t c_den = (i == 0) ? COIN_1 : ((i == 1) ? COIN_2 : COIN_5);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    // Refill and decrement combine in one extra-wide sum so neither is lost.
    always_comb begin
      w_sum = {1'b0, r_cnt};
      if (refill_valid && (refill_denom == c_den))
        w_sum = w_sum + {1'b0, refill_count};
      if (dec_valid && (dec_coin == c_den))
        w_sum = w_sum - (CNT_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_cnt <= CNT_W'(INIT_CNT);
      else if (w_sum[CNT_W])
        r_cnt <= '1;
      else
        r_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign cnt_1 = g_cnt[0].r_cnt;
  assign cnt_2 = g_cnt[1].r_cnt;
  assign cnt_5 = g_cnt[2].r_cnt;

endmodule
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module : vend_change_dispenser
// Brief  : Greedy 5/2/1 change payout driving the coin hopper one coin at a time.
// Rev    : 1.0  initial release
// ============================================================================
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int BAL_W       = 4,
  parameter int CNT_W       = 4,
  parameter int INIT_CNT    = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  wire logic              clk,
  input  wire logic              reset,
  vend_change_dispenser_if.slave bus,
  input  wire logic              refill_valid,
  input  wire logic [2:0]        refill_denom,
  input  wire logic [CNT_W-1:0]  refill_count,
  output logic                   jam,
  input  wire logic              jam_clear,
  output logic      [CNT_W-1:0]  cnt_1,
  output logic      [CNT_W-1:0]  cnt_2,
  output logic      [CNT_W-1:0]  cnt_5
);

  localparam int c_tmr_w = $clog2(ACK_TIMEOUT + 1);

  chg_state_t       r_state, w_state_nxt;
  logic [BAL_W-1:0] r_rem;
  logic [BAL_W-1:0] r_shortfall;
  coin_t            r_coin;
  coin_t            w_pick;
  logic [c_tmr_w-1:0] r_timer;
  logic             w_ack;
  logic             w_timeout;

  vend_coin_store #(
    .CNT_W    (CNT_W),
    .INIT_CNT (INIT_CNT)
  ) u_store (
    .clk          (clk),
    .reset        (reset),
    .refill_valid (refill_valid),
    .refill_denom (refill_denom),
    .refill_count (refill_count),
    .dec_valid    (w_ack),
    .dec_coin     (r_coin),
    .cnt_1        (cnt_1),
    .cnt_2        (cnt_2),
    .cnt_5        (cnt_5)
  );

  // Pure greedy: no backtracking when a larger coin strands the remainder.
  always_comb begin
    w_pick = COIN_NONE;
    if ((r_rem >= BAL_W'(5)) && (cnt_5 != '0))
      w_pick = COIN_5;
    else if ((r_rem >= BAL_W'(2)) && (cnt_2 != '0))
      w_pick = COIN_2;
    else if ((r_rem >= BAL_W'(1)) && (cnt_1 != '0))
      w_pick = COIN_1;
  end

  assign w_ack     = (r_state == S_EMIT) && bus.coin_ack;
  assign w_timeout = (r_state == S_EMIT) && !bus.coin_ack &&
                     (r_timer == c_tmr_w'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.req_ready  = 1'b0;
    bus.coin_valid = 1'b0;
    bus.done       = 1'b0;
    jam            = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = S_SELECT;
      end
      S_SELECT: w_state_nxt = (w_pick != COIN_NONE) ? S_EMIT : S_DONE;
      S_EMIT: begin
        bus.coin_valid = 1'b1;
        if (w_ack)          w_state_nxt = S_SELECT;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_FAULT: begin
        jam = 1'b1;
        if (jam_clear) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem       <= '0;
      r_shortfall <= '0;
      r_coin      <= COIN_NONE;
      r_timer     <= '0;
    end else begin
      r_timer <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_rem       <= bus.req_amount;
            r_shortfall <= '0;
          end
        end
        S_SELECT: begin
          if (w_pick != COIN_NONE) r_coin <= w_pick;
          else                     r_shortfall <= r_rem;
        end
        S_EMIT: begin
          if (w_ack)
            r_rem <= r_rem - BAL_W'(r_coin);
          else if (!w_timeout)
            r_timer <= r_timer + c_tmr_w'(1);
        end
        S_FAULT: begin
          if (jam_clear) r_shortfall <= r_rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.coin_value = r_coin;
  assign bus.shortfall  = r_shortfall;

endmodule
`default_nettype wire

// File: tb/tb_vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module : tb_vend_change_dispenser
// Brief  : Directed self-checking bench for the change dispenser.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vend_change_dispenser;
  import vend_pkg::*;

  localparam int BAL_W = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_change_dispenser_if #(.BAL_W(BAL_W)) bus ();

  logic             refill_valid;
  logic [2:0]       refill_denom;
  logic [CNT_W-1:0] refill_count;
  logic             jam;
  logic             jam_clear;
  logic [CNT_W-1:0] cnt_1, cnt_2, cnt_5;

  vend_change_dispenser #(
    .BAL_W       (BAL_W),
    .CNT_W       (CNT_W),
    .INIT_CNT    (8),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .refill_valid (refill_valid),
    .refill_denom (refill_denom),
    .refill_count (refill_count),
    .jam          (jam),
    .jam_clear    (jam_clear),
    .cnt_1        (cnt_1),
    .cnt_2        (cnt_2),
    .cnt_5        (cnt_5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int got[$];
  int sf;
  int first_cv;
  int done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input int denom, input int count);
    refill_valid = 1'b1;
    refill_denom = 3'(denom);
    refill_count = CNT_W'(count);
    tick();
    refill_valid = 1'b0;
  endtask

  // Scripted hopper: acks every coin on its first cycle and records it.
  task automatic run_payout(input int amt);
    got.delete();
    first_cv = -1;
    done_cyc = -1;
    sf       = -1;
    check("ready_before_req", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = BAL_W'(amt);
    tick();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (bus.done) begin
        sf       = bus.shortfall;
        done_cyc = c;
        break;
      end
      if (bus.coin_valid) begin
        if (first_cv < 0) first_cv = c;
        got.push_back(int'(bus.coin_value));
      end
      bus.coin_ack = bus.coin_valid;
      tick();
    end
    bus.coin_ack = 1'b0;
    if (done_cyc < 0) check("payout_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int cv;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.coin_ack   = 1'b0;
    refill_valid   = 1'b0;
    refill_denom   = '0;
    refill_count   = '0;
    jam_clear      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_ready", bus.req_ready, 1);
    check("rst_coin_valid", bus.coin_valid, 0);
    check("rst_coin_value", bus.coin_value, 0);
    check("rst_done", bus.done, 0);
    check("rst_jam", jam, 0);
    check("rst_shortfall", bus.shortfall, 0);
    check("rst_cnt_1", cnt_1, 8);
    check("rst_cnt_2", cnt_2, 8);
    check("rst_cnt_5", cnt_5, 8);

    // 7 with full inventory -> 5 then 2
    run_payout(7);
    check("t1_ncoins", got.size(), 2);
    if (got.size() == 2) begin
      check("t1_coin0", got[0], 5);
      check("t1_coin1", got[1], 2);
    end
    check("t1_latency", first_cv, 2);
    check("t1_shortfall", sf, 0);
    check("t1_cnt_5", cnt_5, 7);
    check("t1_cnt_2", cnt_2, 7);
    check("t1_cnt_1", cnt_1, 8);

    // drain the 2s, then 4 pays in 1s
    for (int k = 0; k < 7; k++) run_payout(2);
    check("t2_cnt_2_drained", cnt_2, 0);
    run_payout(4);
    check("t2_ncoins", got.size(), 4);
    foreach (got[k]) check("t2_coin_is_1", got[k], 1);
    check("t2_shortfall", sf, 0);
    check("t2_cnt_1", cnt_1, 4);

    // greedy dead end: 6 with {5:1, 2:8, 1:0}
    for (int k = 0; k < 6; k++) run_payout(5);
    run_payout(4);
    refill(2, 8);
    check("t3_cnt_5_pre", cnt_5, 1);
    check("t3_cnt_1_pre", cnt_1, 0);
    check("t3_cnt_2_pre", cnt_2, 8);
    run_payout(6);
    check("t3_ncoins", got.size(), 1);
    if (got.size() == 1) check("t3_coin0", got[0], 5);
    check("t3_shortfall", sf, 1);
    check("t3_cnt_5", cnt_5, 0);

    // asynchronous reset in the middle of a coin presentation
    bus.req_valid  = 1'b1;
    bus.req_amount = BAL_W'(7);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t6_coin_valid_pre", bus.coin_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_coin_valid_async", bus.coin_valid, 0);
    check("t6_cnt_1", cnt_1, 8);
    check("t6_cnt_2", cnt_2, 8);
    check("t6_cnt_5", cnt_5, 8);
    tick();
    reset = 1'b0;
    tick();
    run_payout(0);
    check("t6_zero_done_lat", done_cyc, 2);
    check("t6_zero_ncoins", got.size(), 0);
    check("t6_zero_shortfall", sf, 0);

    // hopper never acks -> jam after 15 cycles of coin_valid
    bus.req_valid  = 1'b1;
    bus.req_amount = BAL_W'(7);
    tick();
    bus.req_valid = 1'b0;
    cv = 0;
    for (int c = 0; c < 40; c++) begin
      if (jam) break;
      if (bus.coin_valid) cv++;
      tick();
    end
    check("t4_valid_cycles", cv, 15);
    check("t4_jam", jam, 1);
    check("t4_coin_valid", bus.coin_valid, 0);
    check("t4_ready", bus.req_ready, 0);
    bus.coin_ack = 1'b1;
    tick();
    bus.coin_ack = 1'b0;
    check("t4_ack_ignored_in_fault", jam, 1);
    jam_clear = 1'b1;
    tick();
    jam_clear = 1'b0;
    check("t4_done", bus.done, 1);
    check("t4_shortfall", bus.shortfall, 7);
    check("t4_jam_cleared", jam, 0);
    tick();
    check("t4_ready_after", bus.req_ready, 1);
    check("t4_cnt_5", cnt_5, 8);
    check("t4_cnt_2", cnt_2, 8);
    check("t4_cnt_1", cnt_1, 8);

    // refill coinciding with a 2-coin ack, saturating at 15
    refill(2, 6);
    check("t5_cnt_2_pre", cnt_2, 14);
    bus.req_valid  = 1'b1;
    bus.req_amount = BAL_W'(2);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("t5_coin_valid", bus.coin_valid, 1);
    check("t5_coin_value", bus.coin_value, 2);
    bus.coin_ack = 1'b1;
    refill_valid = 1'b1;
    refill_denom = 3'd2;
    refill_count = CNT_W'(3);
    tick();
    bus.coin_ack = 1'b0;
    refill_valid = 1'b0;
    check("t5_cnt_2_sat", cnt_2, 15);
    tick();
    check("t5_done", bus.done, 1);
    check("t5_shortfall", bus.shortfall, 0);
    tick();

    refill(1, 15);
    check("t5_cnt_1_sat", cnt_1, 15);
    refill(3, 5);
    check("t5_bad_denom_1", cnt_1, 15);
    check("t5_bad_denom_2", cnt_2, 15);
    check("t5_bad_denom_5", cnt_5, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
